wb_write_queue: RTL and testbench

- Write-side front end for the 32x32 register file: the pipeline write-back stage pushes register writes through a valid/ready handshake.
- The block buffers pushed writes in a small FIFO.
- It drives the register file write port (regwrite, writereg, writedata), retiring at most one write per cycle in order.
- It also exposes a forwarding lookup so decode can see pending writes that have not yet reached the register file.

---
 rtl/wb_write_queue.sv | 99 +++++++++
 tb/tb_wb_write_queue.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order register-write queue with forwarding lookup (option: WBQ_COALESCE_EN)
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     regwrite,
    output logic [ADDR_W-1:0]        writereg,
    output logic [DATA_W-1:0]        writedata,
    input  logic [ADDR_W-1:0]        fwd_reg,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] mem_reg  [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  youngest;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W:0]    cnt;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              store;
    logic              coal_match;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (PTR_W+1)'(DEPTH));
    assign pop      = drain_en & ~empty;
    assign youngest = tail - PTR_W'(1);

`ifdef WBQ_COALESCE_EN
    // The youngest entry is the head exactly when one entry is held; never merge into a retiring write.
    assign coal_match = ~empty & (in_reg != '0) & (mem_reg[youngest] == in_reg)
                        & ~(pop & (cnt == (PTR_W+1)'(1)));
`else
    assign coal_match = 1'b0;
`endif

    assign in_ready  = ~full | pop | coal_match;
    assign push      = in_valid & in_ready;
    assign store     = push & (in_reg != '0) & ~coal_match;

    assign regwrite  = pop;
    assign writereg  = empty ? '0 : mem_reg[head];
    assign writedata = empty ? '0 : mem_data[head];
    assign count     = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (store)
                tail <= tail + PTR_W'(1);
            cnt <= cnt + (PTR_W+1)'(store) - (PTR_W+1)'(pop);
        end
    end

    // Entry storage needs no reset: occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (reset && store) begin
            mem_reg[tail]  <= in_reg;
            mem_data[tail] <= in_data;
        end else if (reset && push && coal_match) begin
            mem_data[youngest] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < cnt) && (fwd_reg != '0) && (mem_reg[idx] == fwd_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data[idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - randomized and directed checks of wb_write_queue against a queue model
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_reg = '0;
    logic [31:0] in_data = '0;
    logic        drain_en = 1'b0;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic [4:0]  fwd_reg = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en), .regwrite(regwrite),
        .writereg(writereg), .writedata(writedata), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .count(count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare just after, advance the model at the rising edge.
    task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic drain, input logic [4:0] fr);
        logic        e_pop, e_ready, e_hit, coal;
        logic [31:0] e_fdata;
        ent_t        e;
        @(negedge clk);
        in_valid = v; in_reg = r; in_data = d; drain_en = drain; fwd_reg = fr;
        #1;
        e_pop = drain && (q.size() != 0);
        coal  = 1'b0;
`ifdef WBQ_COALESCE_EN
        if (q.size() != 0 && r != 0 && q[q.size()-1].r == r && !(e_pop && q.size() == 1))
            coal = 1'b1;
`endif
        e_ready = (q.size() < DEPTH) || e_pop || coal;
        e_hit   = 1'b0;
        e_fdata = '0;
        foreach (q[i]) if (fr != 0 && q[i].r == fr) begin e_hit = 1'b1; e_fdata = q[i].d; end
        check("in_ready",  32'(in_ready),  32'(e_ready));
        check("regwrite",  32'(regwrite),  32'(e_pop));
        check("writereg",  32'(writereg),  q.size() != 0 ? 32'(q[0].r) : 32'd0);
        check("writedata", writedata,      q.size() != 0 ? q[0].d : 32'd0);
        check("fwd_hit",   32'(fwd_hit),   32'(e_hit));
        check("fwd_data",  fwd_data,       e_fdata);
        check("count",     32'(count),     32'(q.size()));
        @(posedge clk);
        if (v && e_ready && r != 0) begin
            if (coal) begin
                e = q.pop_back();
                e.d = d;
                q.push_back(e);
            end else begin
                e.r = r; e.d = d;
                q.push_back(e);
            end
        end
        if (e_pop) void'(q.pop_front());
    endtask

    initial begin
        #12;
        check("reset_count",    32'(count),    32'd0);
        check("reset_regwrite", 32'(regwrite), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // single write, held then drained
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd5);
        step(0, 5'd0, 32'h0, 0, 5'd5);
        check("t1_count", 32'(count), 32'd1);
        step(0, 5'd0, 32'h0, 1, 5'd5);
        step(0, 5'd0, 32'h0, 0, 5'd5);

        // fill, stall, then push and pop together while full
        for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i * 32'h11), 0, 5'd3);
        step(1, 5'd9, 32'h99, 0, 5'd9);
        step(1, 5'd9, 32'h99, 1, 5'd9);
        for (int i = 0; i < 6; i++) step(0, 5'd0, 32'h0, 1, 5'd9);

        // register 0 is accepted but never stored
        step(1, 5'd0, 32'h1234, 0, 5'd0);
        step(0, 5'd0, 32'h0, 1, 5'd0);

        // same-register writes back to back
        step(1, 5'd7, 32'hA, 0, 5'd7);
        step(1, 5'd7, 32'hB, 0, 5'd7);
        step(0, 5'd0, 32'h0, 0, 5'd7);
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1, 5'd7);

        // asynchronous reset between edges with pending writes
        for (int i = 1; i <= 3; i++) step(1, 5'(i + 10), 32'(i), 0, 5'd11);
        @(negedge clk);
        drain_en = 1'b1; in_valid = 1'b0; fwd_reg = 5'd11;
        #2 reset = 1'b0;
        #1;
        check("async_regwrite", 32'(regwrite), 32'd0);
        check("async_count",    32'(count),    32'd0);
        check("async_fwd_hit",  32'(fwd_hit),  32'd0);
        check("async_writereg", 32'(writereg), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 1, 5'd11);

        // continuous stream wraps the pointers
        for (int i = 1; i <= 10; i++) step(1, 5'(i), 32'(32'h100 + i), 1, 5'(i));
        for (int i = 0; i < 2; i++) step(0, 5'd0, 32'h0, 1, 5'd1);

        // random traffic with frequent register collisions
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
